// File: rtl/vx_exec_mem_arb_pkg.sv
// Shared sizing helpers for the execute-stage memory arbiter.
// Holds the tag-width function and the width of the optional stall counters.
package VX_mem_arb_pkg;

    localparam int STALL_CNT_W = 32;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int tag_out_width(input int tag_in_w, input int num_reqs);
        return tag_in_w + clog2_f(num_reqs);
    endfunction

endpackage

// File: rtl/vx_exec_mem_arb_skid.sv
// Two-entry registered skid buffer; ready is registered so it never depends
// on the downstream ready, and the head entry stays stable while stalled.
module VX_skid_buffer #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [DATAW-1:0] data_out
);

    logic [DATAW-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push = valid_in && ready_q;
    assign pop  = (count_q != 2'd0) && ready_out;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            count_q  <= count_d;
            ready_q  <= (count_d != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    assign ready_in  = ready_q;
    assign valid_out = (count_q != 2'd0);
    assign data_out  = mem_q[rd_ptr_q];

endmodule

// File: rtl/vx_exec_mem_arb.sv
// Round-robin N:1 memory request arbiter with tag-steered response demux.
// Optional macro VX_MEM_ARB_PERF_EN adds per-requester saturating stall counters.
module vx_exec_mem_arb
    import VX_mem_arb_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int LANES        = 4,
    parameter int WORD_SIZE    = 4,
    parameter int ADDR_WIDTH   = 30,
    parameter int TAG_IN_WIDTH = 16,
    parameter int TAG_SEL_IDX  = 1
) (
    input  logic                                           clk,
    input  logic                                           reset,
`ifdef VX_MEM_ARB_PERF_EN
    output logic [NUM_REQS*STALL_CNT_W-1:0]                perf_stall_out,
`endif
    input  logic [NUM_REQS-1:0]                            req_valid_in,
    input  logic [NUM_REQS-1:0]                            req_rw_in,
    input  logic [NUM_REQS*LANES*WORD_SIZE-1:0]            req_byteen_in,
    input  logic [NUM_REQS*LANES*ADDR_WIDTH-1:0]           req_addr_in,
    input  logic [NUM_REQS*LANES*WORD_SIZE*8-1:0]          req_data_in,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]               req_tag_in,
    output logic [NUM_REQS-1:0]                            req_ready_in,
    output logic                                           req_valid_out,
    output logic                                           req_rw_out,
    output logic [LANES*WORD_SIZE-1:0]                     req_byteen_out,
    output logic [LANES*ADDR_WIDTH-1:0]                    req_addr_out,
    output logic [LANES*WORD_SIZE*8-1:0]                   req_data_out,
    output logic [tag_out_width(TAG_IN_WIDTH, NUM_REQS)-1:0] req_tag_out,
    input  logic                                           req_ready_out,
    input  logic                                           rsp_valid_in,
    input  logic [LANES-1:0]                               rsp_tmask_in,
    input  logic [LANES*WORD_SIZE*8-1:0]                   rsp_data_in,
    input  logic [tag_out_width(TAG_IN_WIDTH, NUM_REQS)-1:0] rsp_tag_in,
    output logic                                           rsp_ready_in,
    output logic [NUM_REQS-1:0]                            rsp_valid_out,
    output logic [LANES-1:0]                               rsp_tmask_out,
    output logic [LANES*WORD_SIZE*8-1:0]                   rsp_data_out,
    output logic [TAG_IN_WIDTH-1:0]                        rsp_tag_out,
    input  logic [NUM_REQS-1:0]                            rsp_ready_out
);

    localparam int LOG_NUM_REQS  = clog2_f(NUM_REQS);
    localparam int TAG_OUT_WIDTH = tag_out_width(TAG_IN_WIDTH, NUM_REQS);
    localparam int IDX_W         = (LOG_NUM_REQS > 0) ? LOG_NUM_REQS : 1;
    localparam int BE_W          = LANES * WORD_SIZE;
    localparam int AD_W          = LANES * ADDR_WIDTH;
    localparam int DA_W          = LANES * WORD_SIZE * 8;
    localparam int REQ_DW        = 1 + BE_W + AD_W + DA_W + TAG_OUT_WIDTH;
    localparam int RSP_DW        = IDX_W + LANES + DA_W + TAG_IN_WIDTH;
    localparam logic [TAG_OUT_WIDTH-1:0] LO_MASK  = (TAG_OUT_WIDTH'(1) << TAG_SEL_IDX) - TAG_OUT_WIDTH'(1);
    localparam logic [TAG_OUT_WIDTH-1:0] IDX_MASK = (TAG_OUT_WIDTH'(1) << LOG_NUM_REQS) - TAG_OUT_WIDTH'(1);

    logic [IDX_W-1:0]         last_grant_q;
    logic [IDX_W-1:0]         last_grant_d;
    logic [IDX_W-1:0]         grant_idx;
    logic                     grant_valid;
    logic                     req_buf_ready;
    logic                     req_push;
    logic [TAG_OUT_WIDTH-1:0] sel_tag_ext;
    logic [TAG_OUT_WIDTH-1:0] sel_tag_out;
    logic [REQ_DW-1:0]        req_buf_in;
    logic [REQ_DW-1:0]        req_buf_out;

    // Later search positions are overwritten by earlier ones, so the first
    // valid requester after last_grant wins without needing a loop break.
    always_comb begin
        int cand;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int k = NUM_REQS; k >= 1; k--) begin
            cand = (int'(last_grant_q) + k) % NUM_REQS;
            if (req_valid_in[cand]) begin
                grant_idx   = IDX_W'(cand);
                grant_valid = 1'b1;
            end
        end
    end

    assign req_push     = grant_valid && req_buf_ready;
    assign last_grant_d = req_push ? grant_idx : last_grant_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_grant_q <= IDX_W'(NUM_REQS - 1);
        else        last_grant_q <= last_grant_d;
    end

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_ready
        assign req_ready_in[gi] = req_push && (grant_idx == IDX_W'(gi));
    end

    // The requester index is spliced in at TAG_SEL_IDX; with one requester it is zero-width.
    assign sel_tag_ext = TAG_OUT_WIDTH'(req_tag_in[int'(grant_idx)*TAG_IN_WIDTH +: TAG_IN_WIDTH]);
    assign sel_tag_out = ((sel_tag_ext >> TAG_SEL_IDX) << (TAG_SEL_IDX + LOG_NUM_REQS))
                       | ((TAG_OUT_WIDTH'(grant_idx) & IDX_MASK) << TAG_SEL_IDX)
                       | (sel_tag_ext & LO_MASK);

    assign req_buf_in = {req_rw_in[grant_idx],
                         req_byteen_in[int'(grant_idx)*BE_W +: BE_W],
                         req_addr_in[int'(grant_idx)*AD_W +: AD_W],
                         req_data_in[int'(grant_idx)*DA_W +: DA_W],
                         sel_tag_out};

    VX_skid_buffer #(.DATAW(REQ_DW)) req_buf (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (grant_valid),
        .ready_in  (req_buf_ready),
        .data_in   (req_buf_in),
        .valid_out (req_valid_out),
        .ready_out (req_ready_out),
        .data_out  (req_buf_out)
    );

    assign {req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out} = req_buf_out;

    logic [IDX_W-1:0]        rsp_idx;
    logic                    rsp_idx_ok;
    logic [TAG_IN_WIDTH-1:0] rsp_tag_strip;
    logic                    rsp_buf_valid;
    logic                    rsp_sel_ready;
    logic [IDX_W-1:0]        rsp_out_idx;
    logic [NUM_REQS-1:0]     rsp_onehot;
    logic [RSP_DW-1:0]       rsp_buf_out;

    assign rsp_idx       = IDX_W'((rsp_tag_in >> TAG_SEL_IDX) & IDX_MASK);
    assign rsp_idx_ok    = (int'(rsp_idx) < NUM_REQS);
    assign rsp_tag_strip = TAG_IN_WIDTH'(((rsp_tag_in >> (TAG_SEL_IDX + LOG_NUM_REQS)) << TAG_SEL_IDX)
                                         | (rsp_tag_in & LO_MASK));

    // Out-of-range indices are still handshaked but never enter the buffer.
    VX_skid_buffer #(.DATAW(RSP_DW)) rsp_buf (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (rsp_valid_in && rsp_idx_ok),
        .ready_in  (rsp_ready_in),
        .data_in   ({rsp_idx, rsp_tmask_in, rsp_data_in, rsp_tag_strip}),
        .valid_out (rsp_buf_valid),
        .ready_out (rsp_sel_ready),
        .data_out  (rsp_buf_out)
    );

    assign {rsp_out_idx, rsp_tmask_out, rsp_data_out, rsp_tag_out} = rsp_buf_out;

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_rsp
        assign rsp_onehot[gi]    = (rsp_out_idx == IDX_W'(gi));
        assign rsp_valid_out[gi] = rsp_buf_valid && rsp_onehot[gi];
    end

    assign rsp_sel_ready = |(rsp_onehot & rsp_ready_out);

`ifndef SYNTHESIS
    bad_rsp_idx_a: assert property (@(posedge clk) disable iff (!reset)
        !(rsp_valid_in && rsp_ready_in && !rsp_idx_ok))
        else $error("response tag carries out-of-range requester index %0d", rsp_idx);
`endif

`ifdef VX_MEM_ARB_PERF_EN
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_perf
        logic [STALL_CNT_W-1:0] stall_cnt_q;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                stall_cnt_q <= '0;
            end else if (req_valid_in[gi] && !req_ready_in[gi] && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end
        end
        assign perf_stall_out[gi*STALL_CNT_W +: STALL_CNT_W] = stall_cnt_q;
    end
`endif

endmodule

// File: tb/tb_vx_exec_mem_arb.sv
// Directed plus randomized bench for vx_exec_mem_arb against a queue-based model.
// Define VX_MEM_ARB_PERF_EN to also exercise the stall counters.
module tb_vx_exec_mem_arb;

    localparam int NR  = 4;
    localparam int LN  = 4;
    localparam int WS  = 4;
    localparam int AW  = 30;
    localparam int TIW = 16;
    localparam int SEL = 1;
    localparam int LOG = 2;
    localparam int TOW = TIW + LOG;
    localparam int BE  = LN * WS;
    localparam int AD  = LN * AW;
    localparam int DA  = LN * WS * 8;

    logic clk;
    logic reset;
    logic [NR-1:0]     req_valid_in, req_rw_in, req_ready_in;
    logic [NR*BE-1:0]  req_byteen_in;
    logic [NR*AD-1:0]  req_addr_in;
    logic [NR*DA-1:0]  req_data_in;
    logic [NR*TIW-1:0] req_tag_in;
    logic              req_valid_out, req_rw_out, req_ready_out;
    logic [BE-1:0]     req_byteen_out;
    logic [AD-1:0]     req_addr_out;
    logic [DA-1:0]     req_data_out;
    logic [TOW-1:0]    req_tag_out;
    logic              rsp_valid_in, rsp_ready_in;
    logic [LN-1:0]     rsp_tmask_in, rsp_tmask_out;
    logic [DA-1:0]     rsp_data_in, rsp_data_out;
    logic [TOW-1:0]    rsp_tag_in;
    logic [NR-1:0]     rsp_valid_out, rsp_ready_out;
    logic [TIW-1:0]    rsp_tag_out;
`ifdef VX_MEM_ARB_PERF_EN
    logic [NR*32-1:0]  perf_stall_out;
`endif

    vx_exec_mem_arb #(
        .NUM_REQS(NR), .LANES(LN), .WORD_SIZE(WS), .ADDR_WIDTH(AW),
        .TAG_IN_WIDTH(TIW), .TAG_SEL_IDX(SEL)
    ) dut (
        .clk(clk), .reset(reset),
`ifdef VX_MEM_ARB_PERF_EN
        .perf_stall_out(perf_stall_out),
`endif
        .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_byteen_in(req_byteen_in),
        .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .req_ready_in(req_ready_in),
        .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_byteen_out(req_byteen_out),
        .req_addr_out(req_addr_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
        .req_ready_out(req_ready_out),
        .rsp_valid_in(rsp_valid_in), .rsp_tmask_in(rsp_tmask_in), .rsp_data_in(rsp_data_in),
        .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
        .rsp_valid_out(rsp_valid_out), .rsp_tmask_out(rsp_tmask_out), .rsp_data_out(rsp_data_out),
        .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rw;
        logic [BE-1:0] be;
        logic [AD-1:0] addr;
        logic [DA-1:0] data;
        logic [TOW-1:0] tag;
    } req_t;

    typedef struct {
        int             idx;
        logic [LN-1:0]  tm;
        logic [DA-1:0]  data;
        logic [TIW-1:0] tag;
    } rsp_t;

    req_t rq[$];
    rsp_t sq[$];
    int   last_g;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [NR-1:0]  obs_ready, obs_rsp_valid;
    logic           obs_valid;
    logic [TOW-1:0] obs_tag;
    logic [TIW-1:0] obs_rsp_tag;

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Tag arithmetic expressed as place values rather than bit slicing.
    function automatic logic [TOW-1:0] ins_tag(input logic [TIW-1:0] t, input int w);
        longint v, lo, hi;
        v  = longint'(t);
        lo = v % (64'd1 << SEL);
        hi = v / (64'd1 << SEL);
        return TOW'(lo + longint'(w) * (64'd1 << SEL) + hi * (64'd1 << (SEL + LOG)));
    endfunction

    function automatic logic [TIW-1:0] strip_tag(input logic [TOW-1:0] t);
        longint v;
        v = longint'(t);
        return TIW'((v % (64'd1 << SEL)) + (v / (64'd1 << (SEL + LOG))) * (64'd1 << SEL));
    endfunction

    function automatic int tag_idx(input logic [TOW-1:0] t);
        return int'((longint'(t) / (64'd1 << SEL)) % (64'd1 << LOG));
    endfunction

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rand_req_fields();
        for (int i = 0; i < NR; i++) begin
            req_rw_in[i]              = 1'($urandom);
            req_byteen_in[i*BE +: BE] = BE'($urandom);
            req_addr_in[i*AD +: AD]   = AD'(r128());
            req_data_in[i*DA +: DA]   = DA'(r128());
            req_tag_in[i*TIW +: TIW]  = TIW'($urandom);
        end
    endtask

    task automatic clear_inputs();
        req_valid_in  = '0;
        req_ready_out = 1'b0;
        rsp_valid_in  = 1'b0;
        rsp_ready_out = '0;
    endtask

    // Called at posedge+1 with inputs already applied; checks, advances the model, steps one clock.
    task automatic cycle();
        int win, j;
        logic [NR-1:0] exp_rdy;
        req_t ne;
        rsp_t se;
        logic do_req_pop, do_rsp_pop, do_rsp_push;
        #2;
        win = -1;
        for (int k = 1; k <= NR; k++) begin
            j = (last_g + k) % NR;
            if (win < 0 && req_valid_in[j]) win = j;
        end
        exp_rdy = (rq.size() < 2 && win >= 0) ? (NR'(1) << win) : '0;
        obs_ready = req_ready_in;
        obs_valid = req_valid_out;
        obs_tag   = req_tag_out;
        obs_rsp_valid = rsp_valid_out;
        obs_rsp_tag   = rsp_tag_out;
        chk("req_ready_in", req_ready_in, exp_rdy);
        chk("req_valid_out", req_valid_out, rq.size() > 0);
        if (rq.size() > 0) begin
            chk("req_rw_out", req_rw_out, rq[0].rw);
            chk("req_byteen_out", req_byteen_out, rq[0].be);
            chk("req_addr_out", req_addr_out, rq[0].addr);
            chk("req_data_out", req_data_out, rq[0].data);
            chk("req_tag_out", req_tag_out, rq[0].tag);
        end
        chk("rsp_ready_in", rsp_ready_in, sq.size() < 2);
        chk("rsp_valid_out", rsp_valid_out, (sq.size() > 0) ? (NR'(1) << sq[0].idx) : NR'(0));
        if (sq.size() > 0) begin
            chk("rsp_tmask_out", rsp_tmask_out, sq[0].tm);
            chk("rsp_data_out", rsp_data_out, sq[0].data);
            chk("rsp_tag_out", rsp_tag_out, sq[0].tag);
        end
        do_req_pop  = (rq.size() > 0) && req_ready_out;
        do_rsp_pop  = (sq.size() > 0) && rsp_ready_out[sq[0].idx];
        do_rsp_push = rsp_valid_in && (sq.size() < 2) && (tag_idx(rsp_tag_in) < NR);
        if (do_req_pop) void'(rq.pop_front());
        if (do_rsp_pop) void'(sq.pop_front());
        if (exp_rdy != '0) begin
            ne.rw   = req_rw_in[win];
            ne.be   = req_byteen_in[win*BE +: BE];
            ne.addr = req_addr_in[win*AD +: AD];
            ne.data = req_data_in[win*DA +: DA];
            ne.tag  = ins_tag(req_tag_in[win*TIW +: TIW], win);
            rq.push_back(ne);
            last_g = win;
        end
        if (do_rsp_push) begin
            se.idx  = tag_idx(rsp_tag_in);
            se.tm   = rsp_tmask_in;
            se.data = rsp_data_in;
            se.tag  = strip_tag(rsp_tag_in);
            sq.push_back(se);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_req_valid_out", req_valid_out, 1'b0);
        chk("rst_req_ready_in", req_ready_in, '0);
        chk("rst_rsp_valid_out", rsp_valid_out, '0);
        chk("rst_rsp_ready_in", rsp_ready_in, 1'b0);
        clear_inputs();
        rq.delete();
        sq.delete();
        last_g = NR - 1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        clear_inputs();
        rand_req_fields();
        req_valid_in = '1;
        rsp_tmask_in = '0;
        rsp_data_in  = '0;
        rsp_tag_in   = '0;
        #3;
        do_reset();

        // Round-robin with everyone requesting: grants 0,1,2,3,0.
        req_valid_in  = '1;
        req_ready_out = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_req_fields();
            cycle();
            chk("rr_grant", obs_ready, NR'(1) << (k % NR));
            if (k > 0) chk("rr_out_valid", obs_valid, 1'b1);
        end
        req_valid_in = '0;
        cycle();
        cycle();

        // Single requester 2 with tag 0x0005 -> 0x00015 one cycle later.
        req_valid_in = 4'b0100;
        req_tag_in[2*TIW +: TIW] = 16'h0005;
        cycle();
        req_valid_in = '0;
        cycle();
        chk("tag_insert_valid", obs_valid, 1'b1);
        chk("tag_insert", obs_tag, 18'h00015);
        cycle();

        // Backpressure: two entries buffered, then every ready drops.
        req_valid_in  = '1;
        req_ready_out = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_req_fields();
            cycle();
            if (k >= 2) chk("full_no_ready", obs_ready, '0);
        end
        req_valid_in  = '0;
        req_ready_out = 1'b1;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (obs_valid) n++;
        end
        chk("drain_count", n, 2);

        // Response steering to port 2 with port 2 stalled.
        rsp_valid_in  = 1'b1;
        rsp_tag_in    = 18'h00015;
        rsp_tmask_in  = LN'($urandom);
        rsp_data_in   = DA'(r128());
        rsp_ready_out = 4'b1011;
        cycle();
        rsp_valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("rsp_steer", obs_rsp_valid, 4'b0100);
            chk("rsp_strip", obs_rsp_tag, 16'h0005);
        end
        rsp_ready_out = '1;
        cycle();
        cycle();

        // Reset with two requests buffered.
        req_valid_in  = '1;
        req_ready_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_req_fields();
            cycle();
        end
        chk("pre_reset_valid", obs_valid, 1'b1);
        do_reset();
        req_valid_in  = '1;
        req_ready_out = 1'b1;
        rand_req_fields();
        cycle();
        chk("post_reset_grant", obs_ready, 4'b0001);
        chk("post_reset_valid", obs_valid, 1'b0);
        req_valid_in = '0;
        cycle();
        cycle();

        // Randomized traffic on both paths at once.
        for (int k = 0; k < 400; k++) begin
            rand_req_fields();
            req_valid_in  = NR'($urandom);
            req_ready_out = ($urandom % 4) != 0;
            rsp_valid_in  = 1'($urandom);
            rsp_tag_in    = TOW'($urandom);
            rsp_tmask_in  = LN'($urandom);
            rsp_data_in   = DA'(r128());
            rsp_ready_out = NR'($urandom);
            cycle();
        end

`ifdef VX_MEM_ARB_PERF_EN
        do_reset();
        req_ready_out = 1'b0;
        req_valid_in  = 4'b0001;
        cycle();
        cycle();
        req_valid_in = 4'b1000;
        for (int k = 0; k < 10; k++) cycle();
        chk("perf_stall_3", perf_stall_out[3*32 +: 32], 32'd10);
        chk("perf_stall_0", perf_stall_out[0 +: 32], 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_exec_mem_arb.md
VX_EXEC_MEM_ARB -- requirements
Module: VX_exec_mem_arb

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, meaning number of requesters (1..8).
REQ-002 SHALL have parameter LANES, default 4, meaning lanes per request.
REQ-003 SHALL have parameter WORD_SIZE, default 4, meaning bytes per lane.
REQ-004 SHALL have parameter ADDR_WIDTH, default 30, meaning word-address bits per lane.
REQ-005 SHALL have parameter TAG_IN_WIDTH, default 16, meaning requester tag bits.
REQ-006 SHALL have parameter TAG_SEL_IDX, default 1, meaning bit position where the requester index is inserted (0..TAG_IN_WIDTH).
REQ-007 SHALL define localparam LOG_NUM_REQS = clog2(NUM_REQS), and TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS.
REQ-008 SHALL have ports clk in 1, clock; reset in 1, asynchronous active-low reset.
REQ-009 SHALL have ports req_valid_in/req_rw_in in NUM_REQS; req_byteen_in in NUM_REQS*LANES*WORD_SIZE; req_addr_in in NUM_REQS*LANES*ADDR_WIDTH; req_data_in in NUM_REQS*LANES*WORD_SIZE*8; req_tag_in in NUM_REQS*TAG_IN_WIDTH; req_ready_in out NUM_REQS.
REQ-010 SHALL have ports req_valid_out/req_rw_out out 1; req_byteen_out, req_addr_out, req_data_out out one-requester width; req_tag_out out TAG_OUT_WIDTH; req_ready_out in 1.
REQ-011 SHALL have ports rsp_valid_in in 1; rsp_tmask_in in LANES; rsp_data_in in LANES*WORD_SIZE*8; rsp_tag_in in TAG_OUT_WIDTH; rsp_ready_in out 1.
REQ-012 SHALL have ports rsp_valid_out out NUM_REQS; rsp_tmask_out out LANES; rsp_data_out out LANES*WORD_SIZE*8; rsp_tag_out out TAG_IN_WIDTH (shared, qualified by rsp_valid_out); rsp_ready_out in NUM_REQS.

Function
REQ-013 SHALL grant round-robin: search starts at (last_grant+1) mod NUM_REQS; the first valid requester wins.
REQ-014 SHALL assert req_ready_in[i] only for the granted requester, and only when the request buffer can accept.
REQ-015 SHALL advance last_grant only on an input handshake; no handshake leaves it unchanged.
REQ-016 SHALL register accepted requests in a 2-entry skid buffer: req_valid_out rises the cycle after acceptance (latency 1), and throughput is 1 request/cycle while req_ready_out=1.
REQ-017 SHALL hold all req_*_out stable while req_valid_out=1 and req_ready_out=0; a full buffer deasserts every req_ready_in.
REQ-018 SHALL form req_tag_out = {tag_in[TAG_IN_WIDTH-1:TAG_SEL_IDX], grant_idx, tag_in[TAG_SEL_IDX-1:0]}.
REQ-019 SHALL decode idx from rsp_tag_in[TAG_SEL_IDX +: LOG_NUM_REQS] and strip it to produce rsp_tag_out.
REQ-020 SHALL register responses in a 2-entry skid buffer (latency 1); only rsp_valid_out[idx] asserts, and it drains on rsp_ready_out[idx].
REQ-021 SHALL consume and discard a response with idx >= NUM_REQS; a simulation assertion fires on it.
REQ-022 with NUM_REQS=1 SHALL insert no tag bits; buffers remain present and the latency is unchanged.
REQ-023 SHALL keep the request and response paths independent; simultaneous handshakes on both paths are legal every cycle.

Reset
REQ-024 Asserting reset (low) SHALL asynchronously empty both buffers, set last_grant=NUM_REQS-1 (requester 0 wins first), and drive all valid/ready outputs to 0.
REQ-025 Reset asserted mid-transaction SHALL drop buffered entries without emitting them; outputs SHALL be valid again no earlier than 1 cycle after deassertion.

Configuration
REQ-026 When VX_MEM_ARB_PERF_EN is defined, the block SHALL add output perf_stall_out, NUM_REQS*32 bits: per-requester counters incrementing each cycle that req_valid_in[i]=1 and req_ready_in[i]=0. The counters SHALL saturate at 2^32-1 and clear on reset.
REQ-027 When VX_MEM_ARB_PERF_EN is undefined, the port and counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-028 Package VX_mem_arb_pkg SHALL hold the clog2-based tag-width function and the stall-counter width constant (32).
REQ-029 Both buffers SHALL instantiate sub-module VX_skid_buffer (parameter DATAW, 2 entries).

Verification
REQ-030 NUM_REQS=4, all valid continuously, req_ready_out=1 -> grants 0,1,2,3,0; one output per cycle.
REQ-031 Only requester 2 valid with tag 0x0005, TAG_SEL_IDX=1 -> req_tag_out=0x00015 one cycle later.
REQ-032 req_ready_out held 0 for 5 cycles -> 2 requests buffered, then all req_ready_in=0, outputs stable; release -> both emitted in order.
REQ-033 rsp_tag_in=0x00015 -> rsp_valid_out=4'b0100, rsp_tag_out=0x0005; with rsp_ready_out[2]=0 it is held; the other ports are unaffected.
REQ-034 Reset pulled low with 2 requests buffered -> req_valid_out=0 immediately; after release the first grant goes to requester 0.
REQ-035 PERF_EN, requester 3 valid and blocked for 10 cycles -> perf_stall_out[3]=10.
